// File: rtl/exe_muldiv_seq.sv
// Sequential 32-cycle multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
module exe_muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] porta,
    input  logic [DATA_W-1:0] portb,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          state;
    logic [4:0]          cnt;
    logic                is_div;
    logic                neg_lo;
    logic                neg_hi;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   opb;

    logic                idle_like;
    logic                sa;
    logic                sb;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                dz;
    logic [DATA_W:0]     msum;
    logic [DATA_W:0]     dtrial;
    logic                dge;
    logic [2*DATA_W-1:0] prod_neg;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);
    assign done      = (state == DONE);
    assign stall     = (start & ~flush & idle_like) | busy;

    assign sa    = op[0] & porta[DATA_W-1];
    assign sb    = op[0] & portb[DATA_W-1];
    assign mag_a = sa ? (~porta + DATA_W'(1)) : porta;
    assign mag_b = sb ? (~portb + DATA_W'(1)) : portb;
    assign dz    = op[1] & (portb == '0);

    // Multiply: conditionally add the multiplicand into the upper half, keep the carry for the shift.
    assign msum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};

    // Divide: partial remainder is always below the divisor, so bit DATA_W flags a negative trial.
    assign dtrial = {acc_hi, acc_lo[DATA_W-1]} - {1'b0, opb};
    assign dge    = ~dtrial[DATA_W];

    assign prod_neg = ~{acc_hi, acc_lo} + (2*DATA_W)'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_lo   <= sa ^ sb;
                        neg_hi   <= op[1] ? sa : (sa ^ sb);
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        opb      <= mag_b;
                        div_zero <= 1'b0;
                        if (dz) begin
                            state    <= DONE;
                            hi       <= porta;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= dge ? dtrial[DATA_W-1:0]
                                      : {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
                        acc_lo <= {acc_lo[DATA_W-2:0], dge};
                    end else begin
                        {acc_hi, acc_lo} <= {msum, acc_lo[DATA_W-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_lo ? (~acc_lo + DATA_W'(1)) : acc_lo;
                        hi <= neg_hi ? (~acc_hi + DATA_W'(1)) : acc_hi;
                    end else if (neg_lo) begin
                        {hi, lo} <= prod_neg;
                    end else begin
                        {hi, lo} <= {acc_hi, acc_lo};
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed self-checking bench for exe_muldiv_seq.
// Cycle 0 is the cycle in which start is presented; done is expected in cycle 34.
module tb_exe_muldiv_seq;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] porta;
    logic [31:0] portb;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    exe_muldiv_seq #(.DATA_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .op       (op),
        .porta    (porta),
        .portb    (portb),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one operation for a single cycle; returns in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        porta = a;
        portb = b;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle index in which done is seen (100 on timeout).
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        nRST  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        porta = '0;
        portb = '0;
        tick();
        tot_cnt++;
        if ({hi, lo, done, busy, div_zero, stall} !== 68'd0) begin
            $display("FAIL reset_outputs: got hi=%h lo=%h done=%b busy=%b dz=%b stall=%b, want all 0",
                     hi, lo, done, busy, div_zero, stall);
        end else pass_cnt++;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_multu();
        int bad;
        bad   = 0;
        start = 1'b1;
        op    = 2'b00;
        porta = 32'hFFFFFFFF;
        portb = 32'hFFFFFFFF;
        #1;
        tot_cnt++;
        if (stall !== 1'b1) $display("FAIL multu_stall_c0: got %b want 1", stall);
        else pass_cnt++;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (stall !== 1'b1 || done !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        tot_cnt++;
        if (bad != 0) $display("FAIL multu_stall_busy: %0d bad cycles of 33, want 0", bad);
        else pass_cnt++;
        tot_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL multu_done_c34: got done=%b busy=%b stall=%b want 1 0 0", done, busy, stall);
        else pass_cnt++;
        tot_cnt++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
            $display("FAIL multu_result: got %h_%h want fffffffe_00000001", hi, lo);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (done !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
            $display("FAIL multu_after: got done=%b %h_%h want 0 fffffffe_00000001", done, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_mult();
        int n;
        issue(2'b01, 32'hFFFFFFF9, 32'd6);
        wait_done(n);
        tot_cnt++;
        if (n != 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6)
            $display("FAIL mult_neg7x6: got cyc=%0d %h_%h want 34 ffffffff_ffffffd6", n, hi, lo);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_div();
        logic [1:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] eh  [4];
        logic [31:0] el  [4];
        int n;
        ops[0] = 2'b11; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;
        eh[0]  = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
        ops[1] = 2'b10; as[1] = 32'd100; bs[1] = 32'd7;
        eh[1]  = 32'd2; el[1] = 32'd14;
        ops[2] = 2'b11; as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF;
        eh[2]  = 32'd0; el[2] = 32'h80000000;
        ops[3] = 2'b11; as[3] = 32'd7; bs[3] = 32'hFFFFFFFE;
        eh[3]  = 32'd1; el[3] = 32'hFFFFFFFD;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n);
            tot_cnt++;
            if (n != 34 || hi !== eh[i] || lo !== el[i] || div_zero !== 1'b0)
                $display("FAIL div_vec%0d: got cyc=%0d hi=%h lo=%h dz=%b want 34 %h %h 0",
                         i, n, hi, lo, div_zero, eh[i], el[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int n;
        issue(2'b10, 32'd5, 32'd0);
        wait_done(n);
        tot_cnt++;
        if (n != 1 || busy !== 1'b0 || hi !== 32'd5 || lo !== 32'hFFFFFFFF || div_zero !== 1'b1)
            $display("FAIL divu_by_zero: got cyc=%0d busy=%b hi=%h lo=%h dz=%b want 1 0 5 ffffffff 1",
                     n, busy, hi, lo, div_zero);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (done !== 1'b0 || div_zero !== 1'b1 || hi !== 32'd5)
            $display("FAIL dz_hold: got done=%b dz=%b hi=%h want 0 1 5", done, div_zero, hi);
        else pass_cnt++;
        issue(2'b00, 32'd3, 32'd4);
        tot_cnt++;
        if (div_zero !== 1'b0 || busy !== 1'b1)
            $display("FAIL dz_clear: got dz=%b busy=%b want 0 1", div_zero, busy);
        else pass_cnt++;
        wait_done(n);
        tot_cnt++;
        if (n != 34 || hi !== 32'd0 || lo !== 32'd12)
            $display("FAIL multu_3x4: got cyc=%0d %h_%h want 34 0_c", n, hi, lo);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        int seen;
        issue(2'b00, 32'd9, 32'd9);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tot_cnt++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0)
            $display("FAIL flush_idle: got busy=%b stall=%b done=%b want 0 0 0", busy, stall, done);
        else pass_cnt++;
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            tick();
        end
        tot_cnt++;
        if (seen != 0 || hi !== 32'd0 || lo !== 32'd12)
            $display("FAIL flush_no_done: got done_cycles=%0d %h_%h want 0 0_c", seen, hi, lo);
        else pass_cnt++;
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        porta = 32'd2;
        portb = 32'd2;
        #1;
        tot_cnt++;
        if (stall !== 1'b0) $display("FAIL flush_start_stall: got %b want 0", stall);
        else pass_cnt++;
        tick();
        start = 1'b0;
        flush = 1'b0;
        tot_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL flush_start_reject: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1;
        op    = 2'b00;
        porta = 32'd2;
        portb = 32'd3;
        tick();
        wait_done(n);
        tot_cnt++;
        if (n != 34 || lo !== 32'd6 || hi !== 32'd0)
            $display("FAIL b2b_first: got cyc=%0d %h_%h want 34 0_6", n, hi, lo);
        else pass_cnt++;
        porta = 32'd5;
        portb = 32'd7;
        #1;
        tot_cnt++;
        if (stall !== 1'b1) $display("FAIL b2b_stall_done: got %b want 1", stall);
        else pass_cnt++;
        tick();
        start = 1'b0;
        tot_cnt++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_pulse: got done=%b busy=%b want 0 1", done, busy);
        else pass_cnt++;
        wait_done(n);
        tot_cnt++;
        if (n != 34 || lo !== 32'd35 || hi !== 32'd0)
            $display("FAIL b2b_second: got cyc=%0d %h_%h want 34 0_23", n, hi, lo);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (20) tick();
        nRST = 1'b0;
        #1;
        tot_cnt++;
        if ({hi, lo, done, busy, div_zero, stall} !== 68'd0)
            $display("FAIL reset_mid: got hi=%h lo=%h done=%b busy=%b dz=%b stall=%b want all 0",
                     hi, lo, done, busy, div_zero, stall);
        else pass_cnt++;
        tick();
        nRST = 1'b1;
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            tick();
        end
        tot_cnt++;
        if (seen != 0) $display("FAIL reset_abort: got %0d active cycles want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/exe_muldiv_seq.md
EXE_MULDIV_SEQ -- requirements
Module: exe_muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  EX-stage request to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port porta  input  32  operand A (forwarded rdat1); dividend for divide.
REQ-007 SHALL have port portb  input  32  operand B (forwarded rdat2); divisor for divide.
REQ-008 SHALL have port flush  input  1  pipeline flush; aborts any operation.
REQ-009 SHALL have port stall  output  1  freezes IF/ID/EX while the operation is in progress.
REQ-010 SHALL have port busy  output  1  high in CALC and FIX.
REQ-011 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-012 SHALL have port hi  output  32  product[63:32] or remainder.
REQ-013 SHALL have port lo  output  32  product[31:0] or quotient.
REQ-014 SHALL have port div_zero  output  1  set with done when a divide had portb==0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL, in IDLE or DONE with start=1 and flush=0, latch op/porta/portb, clear the counter, and enter CALC; otherwise DONE returns to IDLE.
REQ-017 SHALL, for signed ops, convert operands to magnitudes at latch time and record the result signs: product/quotient sign = signA xor signB; remainder sign = signA.
REQ-018 SHALL, in CALC, perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly 32 cycles (counter 0..31), then enter FIX.
REQ-019 SHALL, in FIX, apply two's-complement negation where the recorded sign requires it, write hi/lo, and enter DONE.
REQ-020 SHALL assert done=1 only in DONE; done rises exactly 34 cycles after the start-accept edge.
REQ-021 SHALL drive stall = (start & ~flush & state in {IDLE, DONE}) | state in {CALC, FIX}, combinationally; stall=0 in DONE unless a new start is accepted.
REQ-022 SHALL ignore start while in CALC or FIX.
REQ-023 SHALL, for DIVU/DIV with portb==0 at accept, skip CALC/FIX, enter DONE next cycle with hi=porta, lo=32'hFFFFFFFF, div_zero=1.
REQ-024 SHALL produce, for DIV 32'h80000000 / 32'hFFFFFFFF, lo=32'h80000000, hi=0 (wrap-around, no exception).
REQ-025 SHALL, on flush in any state, enter IDLE next edge without asserting done and without updating hi/lo; flush has priority over a simultaneous start.
REQ-026 SHALL hold hi/lo/div_zero stable from DONE until the next FIX or divide-by-zero DONE.
REQ-027 SHALL clear div_zero on every accepted start.

Reset
REQ-028 SHALL, while nRST=0, force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, div_zero=0, and all internal operand/partial registers to 0.
REQ-029 SHALL treat reset mid-operation as an abort: no done pulse after release; stall follows REQ-021 from the first edge after release.

Verification
REQ-030 SHALL pass: MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 34 cycles done=1, hi=32'hFFFFFFFE, lo=32'h00000001; stall high cycles 0..33.
REQ-031 SHALL pass: MULT -7 x 6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6.
REQ-032 SHALL pass: DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-033 SHALL pass: DIVU 5 / 0 -> done one cycle after accept, hi=5, lo=32'hFFFFFFFF, div_zero=1, no busy.
REQ-034 SHALL pass: flush at CALC cycle 10 -> IDLE next cycle, no done, hi/lo keep prior values; start asserted with flush -> not accepted.
REQ-035 SHALL pass: start held high in DONE -> new operation accepted, done pulse one cycle only, second result after another 34 cycles; nRST low at CALC cycle 20 -> all outputs 0, no done.
